// File: rtl/matvec_pkg.sv
// Shared types and sizing helpers for the matrix-vector engine.
package matvec_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_B,
        LOAD_A,
        COMPUTE,
        DRAIN
    } state_t;

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matvec_engine_mac_cell.sv
// One systolic MAC stage: accumulates a*b when enabled and forwards b/enable one cell per cycle.
module mac_cell #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 24
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clr_i,
    input  logic                         en_i,
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    output logic                         en_o,
    output logic signed [DATA_WIDTH-1:0] b_o,
    output logic signed [ACC_WIDTH-1:0]  acc_o
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    acc_q;
    logic                           en_q;
    logic signed [DATA_WIDTH-1:0]   b_q;

    assign prod = (2*DATA_WIDTH)'(a_i) * (2*DATA_WIDTH)'(b_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
            en_q  <= 1'b0;
            b_q   <= '0;
        end else begin
            en_q <= en_i;
            b_q  <= b_i;
            if (clr_i) begin
                acc_q <= '0;
            end else if (en_i) begin
                // Sign-extended product; the sum wraps at ACC_WIDTH.
                acc_q <= acc_q + ACC_WIDTH'(prod);
            end
        end
    end

    assign en_o  = en_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/matvec_engine.sv
// Matrix-vector multiplier: streams in B then A, runs a skewed MAC chain, drains C row by row.
module matvec_engine
    import matvec_pkg::*;
#(
    parameter int unsigned ROWS       = 8,
    parameter int unsigned COLS       = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 24
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         acc_mode_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic signed [DATA_WIDTH-1:0] in_data_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic signed [ACC_WIDTH-1:0]  out_data_o,
    output logic                         out_last_o,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int unsigned ROW_W = cnt_w(ROWS);
    localparam int unsigned COL_W = cnt_w(COLS);
    localparam int unsigned CYC_W = cnt_w(ROWS + COLS);

    state_t           state_q;
    logic [COL_W-1:0] beat_q;
    logic [ROW_W-1:0] row_q;
    logic [CYC_W-1:0] cyc_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             done_q;

    logic signed [DATA_WIDTH-1:0] a_buf_q [ROWS][COLS];
    logic signed [DATA_WIDTH-1:0] b_buf_q [COLS];

    logic                         in_fire;
    logic                         clr_acc;
    logic                         en_c   [ROWS+1];
    logic signed [DATA_WIDTH-1:0] b_c    [ROWS+1];
    logic signed [DATA_WIDTH-1:0] a_in   [ROWS];
    logic [COL_W-1:0]             a_col  [ROWS];
    logic signed [ACC_WIDTH-1:0]  acc    [ROWS];
    logic                         unused_tail;

    assign in_fire = in_valid_i && in_ready_q;
    assign clr_acc = (state_q == IDLE) && start_i && !acc_mode_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            row_q       <= '0;
            cyc_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q    <= LOAD_B;
                        beat_q     <= '0;
                        row_q      <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                LOAD_B: begin
                    if (in_fire) begin
                        if (beat_q == COL_W'(COLS - 1)) begin
                            beat_q  <= '0;
                            state_q <= LOAD_A;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                LOAD_A: begin
                    if (in_fire) begin
                        if (beat_q == COL_W'(COLS - 1)) begin
                            beat_q <= '0;
                            if (row_q == ROW_W'(ROWS - 1)) begin
                                row_q      <= '0;
                                cyc_q      <= '0;
                                in_ready_q <= 1'b0;
                                state_q    <= COMPUTE;
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (cyc_q == CYC_W'(ROWS + COLS - 2)) begin
                        cyc_q       <= '0;
                        row_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DRAIN;
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_ready_i) begin
                        if (row_q == ROW_W'(ROWS - 1)) begin
                            row_q       <= '0;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if ((state_q == LOAD_B) && in_fire) begin
            b_buf_q[beat_q] <= in_data_i;
        end
        if ((state_q == LOAD_A) && in_fire) begin
            a_buf_q[row_q][beat_q] <= in_data_i;
        end
    end

    // B and its enable enter cell 0 in column order; later cells see them skewed by their index.
    assign en_c[0] = (state_q == COMPUTE) && (cyc_q < CYC_W'(COLS));
    assign b_c[0]  = (cyc_q < CYC_W'(COLS)) ? b_buf_q[cyc_q[COL_W-1:0]] : '0;

    for (genvar r = 0; r < ROWS; r++) begin : g_cell
        // Column index c-r; only meaningful while the cell's enable is high.
        assign a_col[r] = COL_W'(cyc_q - CYC_W'(r));
        assign a_in[r]  = a_buf_q[r][a_col[r]];

        mac_cell #(
            .DATA_WIDTH(DATA_WIDTH),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_cell (
            .clk_i(clk_i),
            .rst_i(rst_i),
            .clr_i(clr_acc),
            .en_i (en_c[r]),
            .a_i  (a_in[r]),
            .b_i  (b_c[r]),
            .en_o (en_c[r+1]),
            .b_o  (b_c[r+1]),
            .acc_o(acc[r])
        );
    end

    assign unused_tail = en_c[ROWS] ^ (^b_c[ROWS]);

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_valid_q ? acc[row_q] : '0;
    assign out_last_o  = out_valid_q && (row_q == ROW_W'(ROWS - 1));
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_matvec_engine.sv
// Randomized self-checking bench for matvec_engine against a plain-arithmetic matrix-vector model.
module tb_matvec_engine;

    localparam int unsigned ROWS = 8;
    localparam int unsigned COLS = 8;
    localparam int unsigned DW   = 8;
    localparam int unsigned AW   = 24;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 acc_mode;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [AW-1:0] out_data;
    logic                 out_last;
    logic                 busy;
    logic                 done;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     done_cnt = 0;
    int     ma [ROWS][COLS];
    int     mb [COLS];
    longint ref_c [ROWS];

    always #5 clk = ~clk;

    matvec_engine #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .DATA_WIDTH(DW),
        .ACC_WIDTH (AW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .acc_mode_i (acc_mode),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .out_last_o (out_last),
        .busy_o     (busy),
        .done_o     (done)
    );

    always @(negedge clk) if (done) done_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint wrap_acc(input longint x);
        longint m;
        m = x & ((longint'(1) << AW) - 1);
        if (m >= (longint'(1) << (AW - 1))) m -= (longint'(1) << AW);
        return m;
    endfunction

    // C = A*B, optionally added onto the previous C.
    function automatic void model_pass(input bit accm);
        for (int r = 0; r < ROWS; r++) begin
            longint s;
            s = accm ? ref_c[r] : 0;
            for (int k = 0; k < COLS; k++) s += longint'(ma[r][k]) * longint'(mb[k]);
            ref_c[r] = wrap_acc(s);
        end
    endfunction

    function automatic void set_basic();
        for (int k = 0; k < COLS; k++) mb[k] = k + 1;
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < COLS; k++) ma[r][k] = r + 1;
    endfunction

    function automatic void set_const(input int av, input int bv);
        for (int k = 0; k < COLS; k++) mb[k] = bv;
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < COLS; k++) ma[r][k] = av;
    endfunction

    function automatic void set_random();
        for (int k = 0; k < COLS; k++) mb[k] = int'($urandom_range(0, 255)) - 128;
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < COLS; k++) ma[r][k] = int'($urandom_range(0, 255)) - 128;
    endfunction

    function automatic int beat_val(input int n);
        if (n < COLS) return mb[n];
        return ma[(n - COLS) / COLS][(n - COLS) % COLS];
    endfunction

    task automatic check_quiet(input string tag);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_in_ready"}, in_ready, 0);
        check_val({tag, "_out_valid"}, out_valid, 0);
        check_val({tag, "_out_data"}, longint'(out_data), 0);
        check_val({tag, "_out_last"}, out_last, 0);
        check_val({tag, "_done"}, done, 0);
    endtask

    task automatic start_pass(input bit accm);
        check_val("idle_busy", busy, 0);
        start    = 1'b1;
        acc_mode = accm;
        @(negedge clk);
        start    = 1'b0;
        acc_mode = 1'b0;
        check_val("load_busy", busy, 1);
    endtask

    // Streams B then A; optionally pokes start mid-load/compute and measures result latency.
    task automatic load_ops(input bit gaps, input bit poke, input bit wait_out);
        int lat;
        for (int n = 0; n < COLS + ROWS * COLS; n++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
            end
            check_val("load_in_ready", in_ready, 1);
            in_valid = 1'b1;
            in_data  = DW'(beat_val(n));
            start    = poke && (n == COLS + 5);
            @(negedge clk);
            start    = 1'b0;
        end
        in_valid = 1'b0;
        if (!wait_out) return;
        lat = 1;
        while (!out_valid && lat < 60) begin
            start = poke && (lat == 4);
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
        check_val("result_latency", lat, ROWS + COLS);
    endtask

    // mode 0: always ready, 1: stall row 3 for five cycles, 2: random ready.
    task automatic drain(input int mode);
        int idx    = 0;
        int stall  = 0;
        int budget = 0;
        int d0     = done_cnt;
        bit rdy;
        while (idx < ROWS && budget < 400) begin
            if (!out_valid) begin
                check_val("drain_valid_hold", out_valid, 1);
                out_ready = 1'b1;
            end else begin
                check_val("out_data", longint'(out_data), ref_c[idx]);
                check_val("out_last", out_last, (idx == ROWS - 1) ? 1 : 0);
                if (mode == 1) begin
                    rdy = !(idx == 3 && stall < 5);
                    if (!rdy) stall++;
                end else if (mode == 2) begin
                    rdy = 1'($urandom_range(0, 1));
                end else begin
                    rdy = 1'b1;
                end
                out_ready = rdy;
                if (rdy) idx++;
            end
            @(negedge clk);
            budget++;
        end
        out_ready = 1'b1;
        if (idx < ROWS) check_val("drain_timeout", idx, ROWS);
        if (mode == 1) check_val("stall_cycles", stall, 5);
        check_val("done_pulse", done, 1);
        check_val("post_out_valid", out_valid, 0);
        check_val("post_busy", busy, 0);
        @(negedge clk);
        check_val("done_clear", done, 0);
        check_val("done_count", done_cnt - d0, 1);
    endtask

    task automatic full_pass(input bit accm, input bit gaps, input bit poke, input int mode);
        start_pass(accm);
        model_pass(accm);
        load_ops(gaps, poke, 1'b1);
        drain(mode);
    endtask

    initial begin
        int d0;
        rst       = 1'b1;
        start     = 1'b0;
        acc_mode  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        for (int r = 0; r < ROWS; r++) ref_c[r] = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_quiet("reset");

        set_basic();
        full_pass(1'b0, 1'b0, 1'b0, 0);
        full_pass(1'b1, 1'b0, 1'b0, 0);
        full_pass(1'b0, 1'b0, 1'b0, 0);

        set_const(-128, 127);
        full_pass(1'b0, 1'b0, 1'b0, 0);
        set_const(-128, -128);
        full_pass(1'b0, 1'b0, 1'b0, 0);

        set_basic();
        full_pass(1'b0, 1'b1, 1'b0, 1);
        full_pass(1'b0, 1'b0, 1'b1, 0);

        in_valid = 1'b1;
        in_data  = 8'sd99;
        repeat (3) begin
            @(negedge clk);
            check_val("idle_in_ready", in_ready, 0);
            check_val("idle_stays", busy, 0);
        end
        in_valid = 1'b0;

        for (int i = 0; i < 6; i++) begin
            set_random();
            full_pass(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 2);
        end

        // Abandon a pass with reset in compute cycle 4.
        set_basic();
        d0 = done_cnt;
        start_pass(1'b0);
        load_ops(1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_quiet("midreset");
        for (int r = 0; r < ROWS; r++) ref_c[r] = 0;
        repeat (25) @(negedge clk);
        check_val("midreset_no_valid", out_valid, 0);
        check_val("midreset_no_done", done_cnt - d0, 0);
        full_pass(1'b1, 1'b0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matvec_engine.md
Name: matvec_engine

Overview:
- Parametrised matrix-vector multiplier: computes C[r] = sum over k of A[r][k]*B[k] for a ROWS x COLS matrix A and a COLS-element vector B.
- Operands arrive over a single valid/ready stream and are captured in internal operand buffers.
- The product is computed on a skewed systolic chain of ROWS MAC cells. Results drain over a valid/ready stream.
- An accumulate mode supports tiling K > COLS across successive passes. This block is the generalised successor of the fixed 8x8 FIFO/MAC array.

Parameters:
- ROWS, 8, number of matrix rows = number of MAC cells = number of results per pass
- COLS, 8, matrix columns = vector length per pass
- DATA_WIDTH, 8, signed operand width
- ACC_WIDTH, 24, signed accumulator/result width; must be >= 2*DATA_WIDTH

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- start  in  1  begin a pass; sampled only in IDLE
- acc_mode  in  1  sampled with start; 1 = keep accumulators, 0 = clear them
- in_valid  in  1  operand beat valid
- in_ready  out  1  operand beat accepted when in_valid && in_ready
- in_data  in  DATA_WIDTH  signed operand
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_data  out  ACC_WIDTH  signed result C[r]
- out_last  out  1  high with the result for row ROWS-1
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on the DRAIN->IDLE transition

Behaviour:
- Reset (rst high at a clock edge, in any state): state=IDLE; all outputs 0; beat, cycle and row counters 0; accumulators 0. Operand buffers need no reset.
- States: IDLE, LOAD_B, LOAD_A, COMPUTE, DRAIN.
- IDLE:
  - in_ready=0.
  - On start=1: if acc_mode=0, clear all accumulators; go to LOAD_B next cycle.
  - in_valid is ignored in IDLE.
- start or acc_mode in any other state: ignored.
- LOAD_B: in_ready=1. Beat j (0..COLS-1) is written to B[j]. After beat COLS-1 is accepted, go to LOAD_A.
- LOAD_A: in_ready=1. Beats are row-major, beat n written to A[n/COLS][n%COLS]. After beat ROWS*COLS-1 is accepted, go to COMPUTE.
- Gaps in in_valid stall loading without loss.
- COMPUTE:
  - Lasts exactly ROWS+COLS-1 cycles, counted c=0..ROWS+COLS-2.
  - In cycle c, cell r performs acc[r] += A[r][c-r]*B[c-r] only when 0 <= c-r < COLS; otherwise it holds.
  - B enters cell 0 and is forwarded one cell per cycle through a registered b_out.
  - The enable travels with B down the chain.
- Arithmetic:
  - Product is signed DATA_WIDTH x DATA_WIDTH -> 2*DATA_WIDTH, sign-extended to ACC_WIDTH.
  - Accumulation wraps modulo 2^ACC_WIDTH with no saturation.
- Latency: last A beat accepted at cycle t -> COMPUTE occupies t+1..t+ROWS+COLS-1 -> out_valid first high at t+ROWS+COLS (t+16 at the defaults).
- DRAIN:
  - out_valid=1; out_data=acc[row]; out_last=(row==ROWS-1).
  - On handshake, row advances.
  - When out_ready=0, out_data and out_last hold stable.
  - On the handshake of row ROWS-1: go to IDLE, out_valid=0, done=1 for one cycle. Accumulators are retained for a later acc_mode=1 pass.
- Reset mid-operation: the pass is abandoned and no done is issued. The next start must behave as after power-up.

Decomposition:
- Package matvec_pkg:
  - state enum state_t {IDLE, LOAD_B, LOAD_A, COMPUTE, DRAIN}
  - counter-width helpers (clog2 of COLS, ROWS*COLS, ROWS+COLS)
- Sub-module mac_cell:
  - Ports: clk, rst, clr, en_in, a_in, b_in -> en_out, b_out (registered), acc.
  - Parametrised by DATA_WIDTH and ACC_WIDTH.
  - Instantiated ROWS times in a generate chain.
- The top level holds the FSM, counters, operand buffers and output mux.

Test Plan:
- Defaults; B=1..8; A[r][*]=r+1 all columns; acc_mode=0 -> outputs 36,72,...,288 in row order, out_last only on 288, done one pulse, first out_valid exactly 16 cycles after the last A beat.
- Signed extremes; A all -128, B all 127 -> every out_data = -130048; and A all -128, B all -128 -> 131072.
- Repeat the first test with acc_mode=1 without reset -> outputs 72,144,...,576; then with acc_mode=0 -> back to 36..288.
- Backpressure: out_ready low 5 cycles on row 3 -> out_data stays 144 and out_valid stays 1; in_valid toggled 1/0 during loads -> same results as the first test.
- start pulsed during LOAD_A and COMPUTE -> ignored (no state change, results unchanged); in_valid in IDLE -> in_ready=0, no buffer write.
- rst high for one cycle in COMPUTE cycle 4 -> next cycle all outputs 0 and state IDLE, no done; then a full first-test pass yields 36..288.
